barrido_display: RTL and testbench



---
 rtl/barrido_display_pkg.sv | 31 +++
 rtl/prescaler_barrido.sv | 40 ++++
 rtl/barrido_display.sv | 86 ++++++++
 tb/tb_barrido_display.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/barrido_display_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Holds the anode-off pattern, the digit index constants and the anode decode helper.
// No logic of its own; the decode helper is pure combinational.
package barrido_display_pkg;

  // Digit select width and index constants (units .. thousands).
  typedef logic [1:0] dig_sel_t;

  localparam dig_sel_t   DIG_UNI    = 2'd0;
  localparam dig_sel_t   DIG_DEC    = 2'd1;
  localparam dig_sel_t   DIG_CEN    = 2'd2;
  localparam dig_sel_t   DIG_MIL    = 2'd3;

  // Anodes are active-low; all ones means every digit dark.
  localparam logic [3:0] ANODOS_OFF = 4'b1111;

  // Active-low anode pattern for digit 'sel'.
  // The digit is lit only when the slot is past its blanking window ('lit')
  // and the digit is individually enabled in 'mask'.
  function automatic logic [3:0] anodo_decode(input dig_sel_t   sel,
                                              input logic [3:0] mask,
                                              input logic       lit);
    logic [3:0] onehot;
    onehot = 4'b0001 << sel;
    if (lit && mask[sel]) begin
      return ~onehot;
    end
    return ANODOS_OFF;
  endfunction

endpackage

// File: rtl/prescaler_barrido.sv
// Slot prescaler: counts 0..DIV-1 while enabled and flags the last cycle of a slot.
// Latency: cnt is registered; tick is combinational from cnt and en.
// Backpressure: en low freezes the count; there is no other flow control.
//
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset, clears cnt
//   en    - count enable; low holds cnt
//   cnt   - current position inside the slot
//   tick  - high on the final cycle of a slot while enabled
module prescaler_barrido #(
  parameter int DIV       = 50000,
  parameter int ANCHO_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [ANCHO_CNT-1:0] cnt,
  output logic                 tick
);

  localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(DIV - 1);

  logic [ANCHO_CNT-1:0] r_cnt;
  logic                 w_fin;

  assign w_fin = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_fin ? '0 : r_cnt + ANCHO_CNT'(1);
    end
  end

  assign cnt  = r_cnt;
  assign tick = en & w_fin;

endmodule

// File: rtl/barrido_display.sv
// Scan controller for a 4-digit multiplexed 7-segment display: digit select, anode drive, strobes.
// Latency: all outputs registered; an reflects the post-edge slot/count, one edge after inputs.
// Backpressure: en low freezes the scan (count and select held) and blanks every anode.
//
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset
//   en     - scan enable
//   en_dig - per-digit enable, bit k gates anode k during its slot
//   s      - digit select to the 4:1 mux (0 = units .. 3 = thousands)
//   an     - active-low anode drive, at most one bit low
//   strobe - one-cycle pulse on every slot change
//   frame  - one-cycle pulse when s wraps from 3 to 0
module barrido_display
  import barrido_display_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK     = 500,
  parameter int ANCHO_CNT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] en_dig,
  output logic [1:0] s,
  output logic [3:0] an,
  output logic       strobe,
  output logic       frame
);

  // One extra bit so cnt+1 never wraps before the blanking compare.
  localparam logic [ANCHO_CNT:0] BLANK_V = (ANCHO_CNT + 1)'(BLANK);

  logic [ANCHO_CNT-1:0] w_cnt;
  logic                 w_tick;
  logic [ANCHO_CNT:0]   w_cnt_inc;
  logic                 w_lit_nxt;
  dig_sel_t             w_s_nxt;
  logic [3:0]           w_an_nxt;

  dig_sel_t             r_s;
  logic [3:0]           r_an;
  logic                 r_strobe;
  logic                 r_frame;

  prescaler_barrido #(
    .DIV       (DIV),
    .ANCHO_CNT (ANCHO_CNT)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .cnt   (w_cnt),
    .tick  (w_tick)
  );

  // The anode register must hold the decode of the values the counter and
  // select take on this same edge, so predict them here instead of decoding
  // the registered state (which would lag by one cycle).
  // A tick sends cnt to 0, which is always inside the blanking window, so
  // the anodes go dark on exactly the edge the select moves.
  assign w_cnt_inc = {1'b0, w_cnt} + (ANCHO_CNT + 1)'(1);
  assign w_lit_nxt = en & ~w_tick & (w_cnt_inc >= BLANK_V);
  assign w_s_nxt   = w_tick ? r_s + 2'd1 : r_s;
  assign w_an_nxt  = anodo_decode(w_s_nxt, en_dig, w_lit_nxt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s      <= DIG_UNI;
      r_an     <= ANODOS_OFF;
      r_strobe <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_s      <= w_s_nxt;
      r_an     <= w_an_nxt;
      r_strobe <= w_tick;
      r_frame  <= w_tick & (r_s == DIG_MIL);
    end
  end

  assign s      = r_s;
  assign an     = r_an;
  assign strobe = r_strobe;
  assign frame  = r_frame;

endmodule

// File: tb/tb_barrido_display.sv
// Directed bench for barrido_display with DIV=8, BLANK=2, ANCHO_CNT=4.
// Expected values are derived from the elapsed enabled-cycle count t:
// cnt = t mod 8, s = (t div 8) mod 4, anode lit when cnt >= 2.
module tb_barrido_display;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] en_dig;
  logic [1:0] s;
  logic [3:0] an;
  logic       strobe;
  logic       frame;

  int n_checks;
  int n_fail;
  int t;          // enabled cycles since the last reset
  int n_frames;

  barrido_display #(
    .DIV       (DIV),
    .BLANK     (BLANK),
    .ANCHO_CNT (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .en_dig (en_dig),
    .s      (s),
    .an     (an),
    .strobe (strobe),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_an(input int tt, input logic [3:0] mask);
    int cc;
    int ss;
    logic [3:0] pat;
    cc = tt % DIV;
    ss = (tt / DIV) % 4;
    pat = 4'b1111;
    if (cc >= BLANK && mask[ss]) pat[ss] = 1'b0;
    return pat;
  endfunction

  // Run n enabled cycles, checking every output against the t-based formula.
  task automatic run_enabled(input int n, input logic [3:0] mask);
    for (int i = 0; i < n; i++) begin
      step();
      t++;
      chk("s", 32'(s), 32'((t / DIV) % 4));
      chk("an", 32'(an), 32'(exp_an(t, mask)));
      chk("strobe", 32'(strobe), 32'((t % DIV) == 0));
      chk("frame", 32'(frame), 32'((t % (4 * DIV)) == 0));
      if (frame) n_frames++;
    end
  endtask

  int         m_cnt;
  int         m_s;
  logic [1:0] prev_s;
  logic       prev_strobe;
  logic [3:0] m_an;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_frames = 0;
    t        = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    en_dig   = 4'b1111;

    // Reset state.
    step();
    step();
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);

    // Normal scan, all digits enabled: 40 cycles.
    rst_n = 1'b1;
    run_enabled(40, 4'b1111);
    chk("frames_in_40", 32'(n_frames), 32'd1);

    // Hundreds digit (slot 2) masked for a full frame.
    en_dig = 4'b1011;
    run_enabled(32, 4'b1011);
    en_dig = 4'b1111;

    // Move to cnt=5, s=1 (t=77) then freeze for 10 edges.
    run_enabled(5, 4'b1111);
    chk("pre_freeze_an", 32'(an), 32'b1101);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_s", 32'(s), 32'd1);
      chk("frz_an", 32'(an), 32'hF);
      chk("frz_strobe", 32'(strobe), 32'd0);
      chk("frz_frame", 32'(frame), 32'd0);
    end
    en = 1'b1;
    // Resume: cnt 6, 7, then s=2 on the third edge; continue to s=2, cnt=4.
    run_enabled(2, 4'b1111);
    chk("resume_s_still1", 32'(s), 32'd1);
    run_enabled(5, 4'b1111);
    chk("pre_rst_s", 32'(s), 32'd2);
    chk("pre_rst_an", 32'(an), 32'b1011);

    // Mid-slot reset for a single edge.
    rst_n = 1'b0;
    step();
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_strobe", 32'(strobe), 32'd0);
    rst_n = 1'b1;
    t = 0;
    run_enabled(1, 4'b1111);
    chk("post_rst_dark", 32'(an), 32'hF);
    run_enabled(1, 4'b1111);
    chk("post_rst_first_lit", 32'(an), 32'b1110);
    run_enabled(14, 4'b1111);

    // Random en/en_dig with a reference model and invariant monitors.
    m_cnt       = t % DIV;
    m_s         = (t / DIV) % 4;
    prev_s      = s;
    prev_strobe = strobe;
    for (int i = 0; i < 1000; i++) begin
      en     = ($urandom_range(0, 9) < 8);
      en_dig = 4'($urandom_range(0, 15));
      if (en) begin
        if (m_cnt == DIV - 1) begin
          m_cnt = 0;
          m_s   = (m_s + 1) % 4;
        end else begin
          m_cnt++;
        end
      end
      m_an = 4'b1111;
      if (en && m_cnt >= BLANK && en_dig[m_s]) m_an[m_s] = 1'b0;
      step();
      chk("rnd_s", 32'(s), 32'(m_s));
      chk("rnd_an", 32'(an), 32'(m_an));
      chk("mon_onehot", 32'($countones(~an) <= 1), 32'd1);
      chk("mon_dark_on_change", 32'((s != prev_s) && (an != 4'hF)), 32'd0);
      chk("mon_strobe_double", 32'(strobe && prev_strobe), 32'd0);
      prev_s      = s;
      prev_strobe = strobe;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
